// File: rtl/parking_sensor_emulator_if.sv
// Command interface of the parking sensor emulator.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The master holds cmd_dir (and cmd_balk when
// present) stable with cmd_valid. cmd_ready never depends on cmd_valid.
//
// Signals:
//   cmd_valid  master->slave  command request
//   cmd_dir    master->slave  0 = enter, 1 = exit
//   cmd_balk   master->slave  car backs out after the first phase
//                             (present only when PARKING_BALK_EN is defined)
//   cmd_ready  slave->master  slave can accept a command this cycle
interface parking_sensor_emulator_if;
  logic cmd_valid;
  logic cmd_dir;
`ifdef PARKING_BALK_EN
  logic cmd_balk;
`endif
  logic cmd_ready;

`ifdef PARKING_BALK_EN
  modport master (output cmd_valid, output cmd_dir, output cmd_balk, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_balk, output cmd_ready);
`else
  modport master (output cmd_valid, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
`endif
endinterface

// File: rtl/parking_sensor_emulator.sv
// Parking sensor emulator: drives the outer (a) and inner (b) gate-sensor
// lines with the quadrature waveform of a car entering or exiting the lot,
// one command at a time, and tracks the resulting occupancy.
//
// Optional feature: define PARKING_BALK_EN to add cmd_balk, which runs the
// first phase, then both sensors clear for one phase, then the gap, with no
// occupancy change.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous reset, active-low
//   cmd        command interface (slave side): cmd_valid, cmd_dir,
//              [cmd_balk], cmd_ready
//   a, b       outer / inner sensor, 1 = beam blocked (registered)
//   busy       a sequence or gap is in progress (registered)
//   done       one-cycle pulse in the first IDLE cycle after a sequence
//   cmd_err    one-cycle pulse after a rejected command
//   occupancy  cars inside, per completed sequences
//   state_dbg  current FSM state (debug)
module parking_sensor_emulator #(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int MAX_CARS     = 15,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  parking_sensor_emulator_if.slave cmd,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err,
  output logic [CNT_W-1:0]      occupancy,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

  // One counter serves both the phase and the gap timing.
  localparam int CMAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0]    PH_LAST  = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(MAX_CARS);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             balk_q, balk_d;
  logic [CNT_W-1:0] occ_d;
  logic             a_d, b_d, busy_d, done_d, err_d;
  logic             accept, reject, balk_in;

`ifdef PARKING_BALK_EN
  assign balk_in = cmd.cmd_balk;
`else
  assign balk_in = 1'b0;
`endif

  assign cmd.cmd_ready = (state_q == IDLE);
  assign state_dbg     = state_q;
  assign accept        = cmd.cmd_valid && (state_q == IDLE);
  // Entering a full lot or exiting an empty one is impossible.
  assign reject = (!cmd.cmd_dir && (occupancy == OCC_MAX)) ||
                  ( cmd.cmd_dir && (occupancy == '0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      balk_q    <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      balk_q    <= balk_d;
      a         <= a_d;
      b         <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      cmd_err   <= err_d;
      occupancy <= occ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    balk_d  = balk_q;
    occ_d   = occupancy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    a_d     = 1'b0;
    b_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = PH1;
            cnt_d   = '0;
            dir_d   = cmd.cmd_dir;
            balk_d  = balk_in;
          end
        end
      end
      PH1: begin
        if (cnt_q == PH_LAST) begin
          state_d = PH2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH2: begin
        if (cnt_q == PH_LAST) begin
          // A balking car never reaches the third phase.
          state_d = balk_q ? GAP : PH3;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH3: begin
        if (cnt_q == PH_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!balk_q) begin
            occ_d = dir_q ? (occupancy - CNT_W'(1)) : (occupancy + CNT_W'(1));
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Sensor levels are decoded from the next state so they register
    // together with it; consecutive patterns differ in one line only.
    case (state_d)
      PH1:     {a_d, b_d} = dir_d ? 2'b01 : 2'b10;
      PH2:     {a_d, b_d} = balk_d ? 2'b00 : 2'b11;
      PH3:     {a_d, b_d} = dir_d ? 2'b10 : 2'b01;
      default: {a_d, b_d} = 2'b00;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
